serial_adder: RTL and testbench

Parametrised bit-serial adder for the digital-logic lab datapath. One full-adder cell and a carry flip-flop add two WIDTH-bit operands LSB-first, one bit per clock. A start/busy/done handshake controls each operation, and the result is held in output registers until the next operation is accepted. It replaces the combinational full adder where area matters more than latency, and it also serves as the multi-bit building block for later accumulator labs.

---
 rtl/serial_adder.sv | 136 +++++++++++++
 tb/tb_serial_adder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB-first, with start/busy/done handshake.
// Optional subtract mode (sub port) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Returns {carry_out, sum_bit} of a single full-adder cell.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  logic [1:0]       state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] psum_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  logic [1:0]       fa_s;
  logic [WIDTH-1:0] psum_next_s;
  logic             sub_s;
  logic [WIDTH-1:0] b_load_s;
  logic             c_load_s;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_s = sub;
`else
  assign sub_s = 1'b0;
`endif

  // Bit-cell datapath and operand preparation for the accepting edge.
  always_comb begin
    fa_s        = full_add(a_sr_r[0], b_sr_r[0], carry_r);
    psum_next_s = psum_r >> 1'b1;
    psum_next_s[WIDTH-1] = fa_s[0];
    if (sub_s) begin
      b_load_s = ~b;
      c_load_s = 1'b1;
    end else begin
      b_load_s = b;
      c_load_s = cin;
    end
  end

  // Control FSM, shift registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_sr_r  <= '0;
      b_sr_r  <= '0;
      psum_r  <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            a_sr_r  <= a;
            b_sr_r  <= b_load_s;
            carry_r <= c_load_s;
            cnt_r   <= '0;
            psum_r  <= '0;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          a_sr_r  <= a_sr_r >> 1'b1;
          b_sr_r  <= b_sr_r >> 1'b1;
          carry_r <= fa_s[1];
          psum_r  <= psum_next_s;
          cnt_r   <= cnt_r + CW'(1);
          // carry_r here is the carry into the MSB, so ovf is its XOR with the final carry.
          if (cnt_r == LAST_CNT) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            sum_r   <= psum_next_s;
            cout_r  <= fa_s[1];
            ovf_r   <= carry_r ^ fa_s[1];
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances, scoreboard queues of expected results.
// Subtract tests run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [0:0] a1, b1;
  logic       cin1;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub8, sub1;
`endif
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] q8[$];  // {sum, cout, ovf}
  logic [2:0] q1[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub1),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

  function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y,
                                        input logic c, input logic s);
    logic [7:0] yy;
    logic       cc;
    logic [8:0] t;
    logic       v;
    yy = s ? ~y : y;
    cc = s ? 1'b1 : c;
    t  = {1'b0, x} + {1'b0, yy} + {8'd0, cc};
    v  = (x[7] == yy[7]) && (t[7] != x[7]);
    return {t[7:0], t[8], v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted request on dut8 and record its expected result.
  task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s);
    a8 = x; b8 = y; cin8 = c;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = s;
`endif
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    q8.push_back(model8(x, y, c, s));
  endtask

  // Wait (bounded) for done8; lat counts edges since the accepting edge, -1 on timeout.
  task automatic await8(input int already, output int lat);
    lat = -1;
    for (int k = already + 1; k <= already + 20; k++) begin
      tick();
      if (done8 === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [9:0] e;
    int lat, seen;
    rst_n = 1'b0; start8 = 1'b1; start1 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    tick(); tick();
    n_checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
      n_fail++; $display("FAIL reset_state8: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                         busy8, done8, sum8, cout8, ovf8);
    end
    n_checks++;
    if ({busy1, done1, sum1, cout1, ovf1} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_state1: got %b want 00000", {busy1, done1, sum1, cout1, ovf1});
    end
    start8 = 1'b0; start1 = 1'b0; rst_n = 1'b1;
    tick();
    // Complete an op so the abort below has non-zero outputs to clear.
    issue8(8'h12, 8'h34, 1'b0, 1'b0);
    await8(0, lat);
    e = q8.pop_front();
    n_checks++;
    if ({sum8, cout8, ovf8} !== e) begin
      n_fail++; $display("FAIL pre_abort_op: got %h want %h", {sum8, cout8, ovf8}, e);
    end
    issue8(8'hAA, 8'h55, 1'b1, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    void'(q8.pop_back());
    n_checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
      n_fail++; $display("FAIL abort_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                         busy8, done8, sum8, cout8, ovf8);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done8 === 1'b1 || busy8 === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen);
    end
    issue8(8'h03, 8'h04, 1'b0, 1'b0);
    await8(0, lat);
    e = q8.pop_front();
    n_checks++;
    if ({sum8, cout8, ovf8} !== e || sum8 !== 8'h07) begin
      n_fail++; $display("FAIL post_reset_op: got sum=%h want 07", sum8);
    end
  endtask

  task automatic test_width1();
    logic [2:0] e;
    logic       x, y, c, co;
    for (int i = 0; i < 8; i++) begin
      x = i[2]; y = i[1]; c = i[0];
      a1 = x; b1 = y; cin1 = c; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      co = (x & y) | (x & c) | (y & c);
      q1.push_back({x ^ y ^ c, co, c ^ co});
      tick();
      n_checks++;
      if (done1 !== 1'b1) begin
        n_fail++; $display("FAIL w1_done_%0d: got done=%b want 1", i, done1);
      end
      e = q1.pop_front();
      n_checks++;
      if ({sum1, cout1, ovf1} !== e) begin
        n_fail++; $display("FAIL w1_result_%0d: got %b want %b", i, {sum1, cout1, ovf1}, e);
      end
    end
  endtask

  task automatic test_carry_chain();
    logic [9:0] e;
    int lat;
    issue8(8'hFF, 8'h01, 1'b0, 1'b0);
    await8(0, lat);
    n_checks++;
    if (lat !== 8) begin
      n_fail++; $display("FAIL ff01_latency: got %0d want 8", lat);
    end
    e = q8.pop_front();
    n_checks++;
    if ({sum8, cout8, ovf8} !== e || {sum8, cout8, ovf8} !== {8'h00, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL ff01_result: got sum=%h cout=%b ovf=%b want 00 1 0", sum8, cout8, ovf8);
    end
    issue8(8'h7F, 8'h01, 1'b0, 1'b0);
    await8(0, lat);
    e = q8.pop_front();
    n_checks++;
    if ({sum8, cout8, ovf8} !== e || {sum8, cout8, ovf8} !== {8'h80, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL 7f01_result: got sum=%h cout=%b ovf=%b want 80 0 1", sum8, cout8, ovf8);
    end
  endtask

  task automatic test_start_ignored();
    logic [9:0] e;
    int lat, seen;
    issue8(8'h21, 8'h03, 1'b0, 1'b0);
    repeat (3) tick();
    a8 = 8'h10; b8 = 8'h10; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    await8(4, lat);
    n_checks++;
    if (lat !== 8) begin
      n_fail++; $display("FAIL ignored_latency: got %0d want 8", lat);
    end
    e = q8.pop_front();
    n_checks++;
    if ({sum8, cout8, ovf8} !== e) begin
      n_fail++; $display("FAIL ignored_result: got %h want %h", {sum8, cout8, ovf8}, e);
    end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done8 === 1'b1 || busy8 === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL ignored_no_queue: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    int lat;
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 1'b0;
`endif
    tick();
    q8.push_back(model8(8'h11, 8'h22, 1'b0, 1'b0));
    a8 = 8'h40; b8 = 8'h05; cin8 = 1'b1;
    await8(0, lat);
    e = q8.pop_front();
    n_checks++;
    if ({sum8, cout8, ovf8} !== e) begin
      n_fail++; $display("FAIL b2b_first: got %h want %h", {sum8, cout8, ovf8}, e);
    end
    n_checks++;
    if (busy8 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_busy_gap: got busy=%b want 0", busy8);
    end
    q8.push_back(model8(8'h40, 8'h05, 1'b1, 1'b0));
    tick();
    start8 = 1'b0;
    n_checks++;
    if (busy8 !== 1'b1 || sum8 !== 8'h33) begin
      n_fail++; $display("FAIL b2b_hold: got busy=%b sum=%h want 1 33", busy8, sum8);
    end
    await8(1, lat);
    n_checks++;
    if (lat !== 9) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d want 9", lat);
    end
    e = q8.pop_front();
    n_checks++;
    if ({sum8, cout8, ovf8} !== e) begin
      n_fail++; $display("FAIL b2b_second: got %h want %h", {sum8, cout8, ovf8}, e);
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [9:0] e;
    int lat;
    issue8(8'h05, 8'h07, 1'b0, 1'b1);
    await8(0, lat);
    e = q8.pop_front();
    n_checks++;
    if ({sum8, cout8, ovf8} !== e || {sum8, cout8, ovf8} !== {8'hFE, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sub_0507: got sum=%h cout=%b ovf=%b want fe 0 0", sum8, cout8, ovf8);
    end
    issue8(8'h80, 8'h01, 1'b0, 1'b1);
    await8(0, lat);
    e = q8.pop_front();
    n_checks++;
    if ({sum8, cout8, ovf8} !== e || {sum8, cout8, ovf8} !== {8'h7F, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL sub_8001: got sum=%h cout=%b ovf=%b want 7f 1 1", sum8, cout8, ovf8);
    end
    sub8 = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 1'b0; sub1 = 1'b0;
`endif
    test_reset();
    test_width1();
    test_carry_chain();
    test_start_ignored();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
